// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared constants and state encoding for the sprite frame
//               buffer (sprite size, pixel width, coordinate width,
//               transparent code, fill watchdog and FSM state codes).
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    localparam int         c_dim          = 64;
    localparam int         c_pix_w        = 4;
    localparam int         c_coord_w      = 6;
    localparam logic [3:0] c_transparent  = 4'h0;
    localparam int         c_fill_timeout = 8192;

    // FSM state type and its encodings
    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_clear = 3'd1;
    localparam state_t c_st_arm   = 3'd2;
    localparam state_t c_st_fill  = 3'd3;
    localparam state_t c_st_swap  = 3'd4;

    // Linear bank address width for a square sprite of 2**coord_w pixels per side
    function automatic int addr_width(input int coord_w);
        return 2 * coord_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_bank.sv
`default_nettype none
// ============================================================================
// Module      : sprite_bank
// Description : One sprite memory bank: 1 write port / 1 read port
//               synchronous RAM with a registered read (1-cycle latency).
//               Memory contents are never reset; only the read register is.
// Ports       : i_clk    - clock
//               i_rst    - synchronous active-high reset (read register only)
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_raddr  - read address
//               o_rdata  - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_bank #(
    parameter int               ADDR_W  = 12,
    parameter int               PIX_W   = 4,
    parameter logic [PIX_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [PIX_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [PIX_W-1:0]  o_rdata
);

    logic [PIX_W-1:0] r_mem [2**ADDR_W];
    logic [PIX_W-1:0] r_rdata;

    // Storage array kept reset-free so it maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= RST_VAL;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sprite_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_frame_buffer
// Description : Captures a rotated sprite from an upstream generator into a
//               DIM x DIM pixel buffer and serves display reads from it.
//               A capture clears the back bank, kicks the generator, stores
//               every opaque pixel at its transformed coordinate, then
//               publishes the frame.
//               Build option SPRITE_DOUBLE_BUFFER_EN: two banks, reads always
//               see the last complete frame and SWAP flips the banks.
//               Without it a single bank is used and reads return the
//               transparent code while a capture is in progress.
// Ports       : i_clk, i_rst         - clock, synchronous active-high reset
//               i_start              - request a new capture (IDLE only)
//               o_gen_start          - one-cycle start pulse to the generator
//               i_valid, i_pixel     - upstream pixel strobe and code
//               i_h, i_v             - destination column / row
//               o_busy               - high whenever not IDLE
//               o_done               - one-cycle frame-complete pulse
//               o_timeout            - sticky fill watchdog flag
//               i_rd_h, i_rd_v       - display read address
//               o_rd_pixel           - read data, 1-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_frame_buffer
    import sprite_pkg::*;
#(
    parameter int               DIM          = c_dim,
    parameter int               PIX_W        = c_pix_w,
    parameter int               COORD_W      = c_coord_w,
    parameter logic [PIX_W-1:0] TRANSPARENT  = PIX_W'(c_transparent),
    parameter int               FILL_TIMEOUT = c_fill_timeout
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    output logic               o_gen_start,
    input  logic               i_valid,
    input  logic [PIX_W-1:0]   i_pixel,
    input  logic [COORD_W-1:0] i_h,
    input  logic [COORD_W-1:0] i_v,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout,
    input  logic [COORD_W-1:0] i_rd_h,
    input  logic [COORD_W-1:0] i_rd_v,
    output logic [PIX_W-1:0]   o_rd_pixel
);

    localparam int                 c_addr_w    = addr_width(COORD_W);
    localparam int                 c_to_w      = $clog2(FILL_TIMEOUT + 1);
    localparam logic [c_addr_w-1:0] c_last_addr = c_addr_w'(DIM * DIM - 1);
    localparam logic [c_to_w-1:0]   c_to_last   = c_to_w'(FILL_TIMEOUT - 1);

    state_t              r_state;
    logic [c_addr_w-1:0] r_clr_cnt;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                r_seen_valid;
    logic                r_timeout;

    logic                w_fill_end;
    logic                w_we;
    logic [c_addr_w-1:0] w_waddr;
    logic [PIX_W-1:0]    w_wdata;
    logic [c_addr_w-1:0] w_raddr;

    // Fill completes on the first idle cycle after the stream has started;
    // an idle gap before the first pixel is just generator start-up latency.
    assign w_fill_end = (r_state == c_st_fill) && !i_valid && r_seen_valid;

`ifdef SPRITE_DOUBLE_BUFFER_EN
    logic r_front;
`endif

    // ------------------------------------------------------------------------
    // Control FSM, clear counter and fill watchdog
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= c_st_idle;
            r_clr_cnt    <= '0;
            r_to_cnt     <= '0;
            r_seen_valid <= 1'b0;
            r_timeout    <= 1'b0;
`ifdef SPRITE_DOUBLE_BUFFER_EN
            r_front      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_start) begin
                        r_state   <= c_st_clear;
                        r_clr_cnt <= '0;
                        r_timeout <= 1'b0;
                    end
                end
                c_st_clear: begin
                    if (r_clr_cnt == c_last_addr) begin
                        r_state   <= c_st_arm;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                c_st_arm: begin
                    r_state      <= c_st_fill;
                    r_to_cnt     <= '0;
                    r_seen_valid <= 1'b0;
                end
                c_st_fill: begin
                    if (i_valid) begin
                        r_seen_valid <= 1'b1;
                    end
                    // A falling edge in the last watchdog cycle still counts
                    // as a normal end of frame.
                    if (w_fill_end) begin
                        r_state <= c_st_swap;
                    end else if (r_to_cnt == c_to_last) begin
                        r_state   <= c_st_swap;
                        r_timeout <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                c_st_swap: begin
                    r_state <= c_st_idle;
`ifdef SPRITE_DOUBLE_BUFFER_EN
                    r_front <= ~r_front;
`endif
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != c_st_idle);
    assign o_gen_start = (r_state == c_st_arm);
    assign o_done      = (r_state == c_st_swap);
    assign o_timeout   = r_timeout;

    // ------------------------------------------------------------------------
    // Back-bank write port: CLEAR sweeps in raster order; FILL stores only
    // opaque pixels so a later transparent sample never erases an earlier one.
    // ------------------------------------------------------------------------
    always_comb begin
        w_we    = 1'b0;
        w_waddr = {i_v, i_h};
        w_wdata = i_pixel;
        if (r_state == c_st_clear) begin
            w_we    = 1'b1;
            w_waddr = r_clr_cnt;
            w_wdata = TRANSPARENT;
        end else if ((r_state == c_st_fill) && i_valid && (i_pixel != TRANSPARENT)) begin
            w_we = 1'b1;
        end
    end

    assign w_raddr = {i_rd_v, i_rd_h};

    // ------------------------------------------------------------------------
    // Bank storage
    // ------------------------------------------------------------------------
`ifdef SPRITE_DOUBLE_BUFFER_EN
    logic [PIX_W-1:0] w_bank_rd [2];
    logic             r_rd_sel;

    // Bank k is the back bank whenever it is not the front bank
    for (genvar k = 0; k < 2; k++) begin : g_bank
        sprite_bank #(
            .ADDR_W  (c_addr_w),
            .PIX_W   (PIX_W),
            .RST_VAL (TRANSPARENT)
        ) u_bank (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_we    (w_we && (r_front != 1'(k))),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_raddr (w_raddr),
            .o_rdata (w_bank_rd[k])
        );
    end

    // Remember which bank was front when the address was sampled so the
    // returned data stays coherent across the swap edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_sel <= 1'b0;
        end else begin
            r_rd_sel <= r_front;
        end
    end

    assign o_rd_pixel = w_bank_rd[r_rd_sel];
`else
    logic [PIX_W-1:0] w_bank_rd;
    logic             r_rd_mask;

    sprite_bank #(
        .ADDR_W  (c_addr_w),
        .PIX_W   (PIX_W),
        .RST_VAL (TRANSPARENT)
    ) u_bank (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_bank_rd)
    );

    // The only bank is being rewritten while busy, so hide it from the display
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_mask <= 1'b0;
        end else begin
            r_rd_mask <= (r_state != c_st_idle);
        end
    end

    assign o_rd_pixel = r_rd_mask ? TRANSPARENT : w_bank_rd;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_frame_buffer
// Description : Scoreboard bench for sprite_frame_buffer. Stimulus tasks
//               drive captures and display reads and push expected results
//               from a bank-level reference model; a negedge monitor pops
//               and compares whenever the DUT presents a result.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sprite_frame_buffer;

    localparam int         DIM   = 64;
    localparam int         NPIX  = DIM * DIM;
    localparam int         TOUT  = 8192;
    localparam logic [3:0] TR    = 4'h0;
`ifdef SPRITE_DOUBLE_BUFFER_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    localparam int P_BUSY  = 0;
    localparam int P_TOUT  = 1;
    localparam int P_PULSE = 2;
    localparam int P_RDPIX = 3;
    localparam int P_BOUND = 4;
    localparam int P_END   = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic [3:0] pixel = '0;
    logic [5:0] h = '0, v = '0, rd_h = '0, rd_v = '0;
    logic       gen_start, busy, done, timeout;
    logic [3:0] rd_pixel;

    always #5 clk = ~clk;

    sprite_frame_buffer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_gen_start (gen_start),
        .i_valid     (valid),
        .i_pixel     (pixel),
        .i_h         (h),
        .i_v         (v),
        .o_busy      (busy),
        .o_done      (done),
        .o_timeout   (timeout),
        .i_rd_h      (rd_h),
        .i_rd_v      (rd_v),
        .o_rd_pixel  (rd_pixel)
    );

    // ---------------- reference model: physical banks + front index --------
    logic [3:0] mem_m [2][NPIX];
    int         front_m = 0;
    bit         busy_m  = 1'b0;

    function automatic int back_idx();
        return DBL ? (1 - front_m) : front_m;
    endfunction

    // ---------------- scoreboard queues ------------------------------------
    typedef struct { int cyc; bit to; } done_t;
    typedef struct { int kind; int exp; } probe_t;

    int         gen_q[$];
    done_t      done_q[$];
    logic [3:0] rd_q[$];
    probe_t     probe_q[$];

    int   cyc = 0;
    logic rd_req = 1'b0, rd_req_d = 1'b0;
    int   errors = 0, checks = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    // ---------------- monitor ----------------------------------------------
    logic [3:0] m_e;
    int         m_g;
    done_t      m_d;
    probe_t     m_p;
    always @(negedge clk) begin
        if (rd_req_d) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_pixel: result %0h with no read outstanding", rd_pixel);
            end else begin
                m_e = rd_q.pop_front();
                if (rd_pixel !== m_e) begin
                    errors++;
                    $display("FAIL rd_pixel: got %0h expected %0h (cycle %0d)", rd_pixel, m_e, cyc);
                end
            end
        end
        if (gen_start === 1'b1) begin
            checks++;
            if (gen_q.size() == 0) begin
                errors++;
                $display("FAIL gen_start: unexpected pulse at cycle %0d expected none", cyc);
            end else begin
                m_g = gen_q.pop_front();
                if (cyc != m_g) begin
                    errors++;
                    $display("FAIL gen_start: at cycle %0d expected cycle %0d", cyc, m_g);
                end
            end
        end
        if (done === 1'b1) begin
            checks++;
            if (done_q.size() == 0) begin
                errors++;
                $display("FAIL done: unexpected pulse at cycle %0d expected none", cyc);
            end else begin
                m_d = done_q.pop_front();
                if (cyc != m_d.cyc || timeout !== m_d.to) begin
                    errors++;
                    $display("FAIL done: cycle %0d timeout %0b expected cycle %0d timeout %0b",
                             cyc, timeout, m_d.cyc, m_d.to);
                end
            end
        end
        while (probe_q.size() > 0) begin
            m_p = probe_q.pop_front();
            checks++;
            case (m_p.kind)
                P_BUSY: if (busy !== m_p.exp[0]) begin
                    errors++;
                    $display("FAIL busy: got %0b expected %0b (cycle %0d)", busy, m_p.exp[0], cyc);
                end
                P_TOUT: if (timeout !== m_p.exp[0]) begin
                    errors++;
                    $display("FAIL timeout: got %0b expected %0b (cycle %0d)", timeout, m_p.exp[0], cyc);
                end
                P_PULSE: if ({gen_start, done} !== m_p.exp[1:0]) begin
                    errors++;
                    $display("FAIL pulses: gen_start,done got %0b%0b expected %0b",
                             gen_start, done, m_p.exp[1:0]);
                end
                P_RDPIX: if (rd_pixel !== m_p.exp[3:0]) begin
                    errors++;
                    $display("FAIL reset_rd_pixel: got %0h expected %0h", rd_pixel, m_p.exp[3:0]);
                end
                P_BOUND: begin
                    errors++;
                    $display("FAIL wait_bound: gen_start wait %0d expired got none expected pulse", m_p.exp);
                end
                default: if (gen_q.size() + done_q.size() + rd_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: outstanding gen=%0d done=%0d rd=%0d expected 0",
                             gen_q.size(), done_q.size(), rd_q.size());
                end
            endcase
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        start  = 1'b0;
    endtask

    task automatic probe(input int kind, input int exp);
        probe_t p;
        p.kind = kind;
        p.exp  = exp;
        probe_q.push_back(p);
    endtask

    task automatic issue_read(input logic [5:0] rh, input logic [5:0] rv);
        rd_h   = rh;
        rd_v   = rv;
        rd_req = 1'b1;
        rd_q.push_back((!DBL && busy_m) ? TR : mem_m[front_m][{rv, rh}]);
    endtask

    task automatic start_frame();
        int b;
        start = 1'b1;
        gen_q.push_back(cyc + 4097);
        busy_m = 1'b1;
        b = back_idx();
        for (int i = 0; i < NPIX; i++) mem_m[b][i] = TR;
        tick();
    endtask

    task automatic wait_gen(input int id, output int g);
        bit seen;
        seen = 1'b0;
        g    = cyc;
        for (int n = 0; n < 5000 && !seen; n++) begin
            @(negedge clk);
            if (gen_start === 1'b1) begin
                seen = 1'b1;
                g    = cyc;
            end
        end
        if (!seen) probe(P_BOUND, id);
        tick();
    endtask

    task automatic fill_pixel(input logic [5:0] ph, input logic [5:0] pv, input logic [3:0] p,
                              input bit do_rd, input logic [5:0] rh, input logic [5:0] rv);
        valid = 1'b1;
        pixel = p;
        h     = ph;
        v     = pv;
        if (p != TR) mem_m[back_idx()][{pv, ph}] = p;
        if (do_rd) issue_read(rh, rv);
        tick();
    endtask

    task automatic model_done();
        if (DBL) front_m = 1 - front_m;
        busy_m = 1'b0;
    endtask

    task automatic end_fill();
        done_t d;
        valid  = 1'b0;
        d.cyc  = cyc + 1;
        d.to   = 1'b0;
        done_q.push_back(d);
        tick();
        tick();
        model_done();
    endtask

    // ---------------- main sequence ----------------------------------------
    int g;
    int wr_a[$];

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        probe(P_BUSY, 0);
        probe(P_TOUT, 0);
        probe(P_PULSE, 0);
        probe(P_RDPIX, TR);
        tick();
        rst = 1'b0;
        tick();

        // Clear and fill, with an ignored i_start during CLEAR
        start_frame();
        repeat (100) tick();
        start = 1'b1;
        tick();
        wait_gen(1, g);
        probe(P_BUSY, 1);
        repeat (10) fill_pixel(6'd3, 6'd7, 4'h5, 1'b0, 6'd0, 6'd0);
        end_fill();
        probe(P_BUSY, 0);
        issue_read(6'd3, 6'd7); tick();
        issue_read(6'd0, 6'd0); tick();

        // Transparency priority
        start_frame();
        wait_gen(2, g);
        fill_pixel(6'd10, 6'd10, 4'h9, 1'b0, 6'd0, 6'd0);
        fill_pixel(6'd10, 6'd10, 4'h0, 1'b0, 6'd0, 6'd0);
        fill_pixel(6'd20, 6'd5,  4'h7, 1'b0, 6'd0, 6'd0);
        fill_pixel(6'd20, 6'd5,  4'hA, 1'b0, 6'd0, 6'd0);
        end_fill();
        issue_read(6'd10, 6'd10); tick();
        issue_read(6'd20, 6'd5);  tick();

        // Reset mid-FILL
        start_frame();
        wait_gen(3, g);
        for (int i = 0; i < 5; i++)
            fill_pixel(6'(i + 30), 6'd10, 4'hE, 1'b0, 6'd0, 6'd0);
        valid = 1'b0;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        front_m = 0;
        busy_m  = 1'b0;
        probe(P_BUSY, 0);
        tick();
        issue_read(6'd10, 6'd10); tick();
        issue_read(6'd30, 6'd10); tick();
        issue_read(6'd20, 6'd5);  tick();

        // Double buffer: frame A then frame B with reads during capture
        start_frame();
        wait_gen(4, g);
        fill_pixel(6'd1, 6'd1, 4'h3, 1'b0, 6'd0, 6'd0);
        end_fill();
        issue_read(6'd1, 6'd1); tick();
        start_frame();
        wait_gen(5, g);
        for (int i = 0; i < 4; i++)
            fill_pixel(6'(i), 6'd1, 4'hC, 1'b1, 6'd1, 6'd1);
        end_fill();
        issue_read(6'd1, 6'd1); tick();

        // Fill watchdog
        begin
            done_t d;
            start_frame();
            wait_gen(6, g);
            d.cyc = g + TOUT + 1;
            d.to  = 1'b1;
            done_q.push_back(d);
            repeat (TOUT) tick();
            probe(P_TOUT, 1);
            tick();
            model_done();
        end
        probe(P_TOUT, 1);
        issue_read(6'd1, 6'd1);  tick();
        issue_read(6'd3, 6'd7);  tick();
        issue_read(6'd63, 6'd63); tick();

        // Randomized frames
        for (int f = 0; f < 3; f++) begin
            int n;
            logic [5:0] rh, rv, ph, pv;
            logic [3:0] p;
            start_frame();
            probe(P_TOUT, 0);
            wait_gen(7 + f, g);
            wr_a.delete();
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) begin
                ph = 6'($urandom_range(0, 15));
                pv = 6'($urandom_range(0, 15));
                p  = 4'($urandom_range(0, 15));
                rh = 6'($urandom_range(0, 63));
                rv = 6'($urandom_range(0, 63));
                wr_a.push_back({pv, ph});
                fill_pixel(ph, pv, p, ($urandom_range(0, 3) == 0), rh, rv);
            end
            end_fill();
            foreach (wr_a[i]) begin
                issue_read(wr_a[i][5:0], wr_a[i][11:6]);
                tick();
            end
            for (int i = 0; i < 8; i++) begin
                issue_read(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
                tick();
            end
        end

        repeat (3) tick();
        probe(P_END, 0);
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_frame_buffer.md
SPRITE_FRAME_BUFFER -- requirements
Module: sprite_frame_buffer

Interface
REQ-001 The block SHALL have parameter DIM, default 64, giving the sprite width and height in pixels.
REQ-002 The block SHALL have parameter PIX_W, default 4, giving the encoded pixel width.
REQ-003 The block SHALL have parameter COORD_W, default 6, equal to log2(DIM).
REQ-004 The block SHALL have parameter TRANSPARENT, default 4'h0, the pixel code meaning "no pixel".
REQ-005 The block SHALL have parameter FILL_TIMEOUT, default 8192, the watchdog limit in cycles for the FILL state.
REQ-006 The block SHALL have port i_clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port i_rst, input, width 1: reset, synchronous and active-high.
REQ-008 The block SHALL have port i_start, input, width 1: requests capture of a new rotated sprite.
REQ-009 The block SHALL have port o_gen_start, output, width 1: a one-cycle start pulse to the upstream rotation generator.
REQ-010 The block SHALL have port i_valid, input, width 1: the upstream pixel-valid strobe.
REQ-011 The block SHALL have port i_pixel, input, width PIX_W: the upstream encoded pixel.
REQ-012 The block SHALL have ports i_h and i_v, input, width COORD_W each: the transformed destination column and row.
REQ-013 The block SHALL have port o_busy, output, width 1: high in every state other than IDLE.
REQ-014 The block SHALL have port o_done, output, width 1: a one-cycle pulse when a frame is complete.
REQ-015 The block SHALL have port o_timeout, output, width 1: sticky flag, cleared by i_rst or by an accepted i_start.
REQ-016 The block SHALL have ports i_rd_h and i_rd_v, input, width COORD_W each: display read address.
REQ-017 The block SHALL have port o_rd_pixel, output, width PIX_W: registered read data with 1-cycle latency.

Function
REQ-018 The FSM SHALL have the states IDLE, CLEAR, ARM, FILL and SWAP.
REQ-019 IDLE SHALL transition to CLEAR when i_start=1; i_start in any other state SHALL be ignored.
REQ-020 CLEAR SHALL write TRANSPARENT to all DIM*DIM back-bank locations, one per cycle in raster order (DIM*DIM cycles), and SHALL then transition to ARM.
REQ-021 ARM SHALL assert o_gen_start for exactly one cycle and SHALL then transition to FILL.
REQ-022 In FILL, when i_valid=1 and i_pixel!=TRANSPARENT, the block SHALL write i_pixel to back-bank address {i_v,i_h} in the same cycle.
REQ-023 In FILL, a transparent input pixel SHALL NOT be written, so that an opaque pixel is never overwritten by a transparent one.
REQ-024 When two writes target the same address, the last write SHALL win.
REQ-025 FILL SHALL end on the first cycle where i_valid=0 after at least one cycle with i_valid=1, and SHALL then transition to SWAP.
REQ-026 If no falling edge of i_valid occurs within FILL_TIMEOUT cycles of entering FILL, the block SHALL set o_timeout and transition to SWAP.
REQ-027 SWAP SHALL pulse o_done for one cycle, SHALL swap the front and back banks (when double buffering is enabled), and SHALL then transition to IDLE.
REQ-028 i_valid=1 outside FILL SHALL be ignored and SHALL NOT write memory.
REQ-029 Reads SHALL always address the front bank: o_rd_pixel = front[{i_rd_v,i_rd_h}], one cycle after the address is presented.
REQ-030 A read and a write in the same cycle SHALL NOT interfere, because they target different banks.

Reset
REQ-031 On i_rst=1 at a clock edge, the block SHALL go to IDLE and SHALL set o_gen_start=0, o_busy=0, o_done=0, o_timeout=0, o_rd_pixel=TRANSPARENT, front bank select=0, and all counters to 0.
REQ-032 Reset SHALL NOT clear memory contents; a reset during CLEAR or FILL SHALL abandon the frame without a swap, and the front bank SHALL be left unchanged.

Configuration
REQ-033 With macro SPRITE_DOUBLE_BUFFER_EN defined, the block SHALL instantiate two DIM*DIM banks and swap them in SWAP.
REQ-034 Without SPRITE_DOUBLE_BUFFER_EN, the block SHALL use a single bank that serves as both front and back.
REQ-035 Without SPRITE_DOUBLE_BUFFER_EN, o_rd_pixel SHALL be TRANSPARENT whenever o_busy=1 (one cycle after the address is presented), and SWAP SHALL perform no bank swap.

Structure
REQ-036 Package sprite_pkg SHALL hold the state enum, DIM, PIX_W, COORD_W and TRANSPARENT.
REQ-037 The block SHALL contain one sub-module, sprite_bank: a single-bank 1-write / 1-read synchronous RAM with registered read, instantiated once or twice.
REQ-038 The FSM, the clear counter and the timeout counter SHALL reside in the top level.

Verification
REQ-039 Clear and fill: pulse i_start; feed 10 valid pixels of 4'h5 at (h=3,v=7), then drop i_valid -> o_gen_start fires exactly 4097 cycles after i_start, o_done pulses once, and a read at (3,7) returns 4'h5 while a read at (0,0) returns 4'h0.
REQ-040 Transparency priority: write 4'h9 at (10,10), then 4'h0 at (10,10) -> read returns 4'h9.
REQ-041 Timeout: hold i_valid=0 after o_gen_start -> after 8192 cycles o_timeout=1, o_done pulses, and the new front bank is all 4'h0.
REQ-042 Double buffer (SPRITE_DOUBLE_BUFFER_EN defined): frame A holds 4'h3 at (1,1); during capture of frame B, reads of (1,1) return 4'h3; after B's o_done, (1,1) returns B's value.
REQ-043 Reset mid-FILL: assert i_rst after 5 pixels -> o_busy=0 the next cycle, no o_done, and the front bank is unchanged.
REQ-044 Busy ignore: i_start pulsed during CLEAR -> exactly one o_gen_start and one o_done.
